reg_manager: RTL and testbench

Architectural register file and scoreboard that terminates the write-back bus (`wb`, `wb_valid`) and supplies source operands to the execute stages. It accepts one decoded instruction per cycle and detects RAW/WAW hazards against in-flight destinations, stalling until the hazard clears. It bypasses same-cycle write-back data and presents operands through a one-entry registered valid/ready output stage.

---
 rtl/reg_manager.sv | 131 +++++++++++++
 tb/tb_reg_manager.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_manager.sv
// Architectural register file with scoreboard: terminates write-back, detects RAW/WAW
// hazards against in-flight destinations, and issues bypassed operands through a one-entry stage.

package cpu_parameters;
    localparam int xlen = 32;
    localparam int nreg = 32;

    typedef struct packed {
        logic [xlen-1:0] data;
        logic [4:0]      adr;
    } wb_bus;
endpackage

module reg_manager
    import cpu_parameters::*;
(
    input  logic            clk,
    input  logic            rst,
    input  wb_bus           wb,
    input  logic            wb_valid,
    input  logic            flush,
    input  logic            dec_valid,
    output logic            dec_ready,
    input  logic [4:0]      dec_rs1,
    input  logic [4:0]      dec_rs2,
    input  logic [4:0]      dec_rd,
    input  logic            dec_rs1_use,
    input  logic            dec_rs2_use,
    input  logic            dec_rd_we,
    output logic            iss_valid,
    input  logic            iss_ready,
    output logic [xlen-1:0] iss_rs1_data,
    output logic [xlen-1:0] iss_rs2_data,
    output logic [4:0]      iss_rd,
    output logic            iss_rd_we
);

    logic [xlen-1:0] rf [nreg];
    logic [nreg-1:1] busy;

    logic [nreg-1:0] busy_all;
    logic [nreg-1:0] busy_set;
    logic [nreg-1:0] busy_clr;
    logic [nreg-1:0] busy_nxt;
    logic            wb_write;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            rd_hit;
    logic            hazard;
    logic            accept;
    logic [xlen-1:0] rs1_val;
    logic [xlen-1:0] rs2_val;

    assign wb_write = wb_valid && (wb.adr != 5'd0);
    assign rs1_hit  = wb_write && (wb.adr == dec_rs1);
    assign rs2_hit  = wb_write && (wb.adr == dec_rs2);
    assign rd_hit   = wb_write && (wb.adr == dec_rd);

    // x0 is never busy: bit 0 of the full-width view is tied low.
    assign busy_all = {busy, 1'b0};

    assign hazard = (dec_rs1_use && busy_all[dec_rs1] && !rs1_hit)
                 || (dec_rs2_use && busy_all[dec_rs2] && !rs2_hit)
                 || (dec_rd_we   && busy_all[dec_rd]  && !rd_hit);

    assign dec_ready = !flush && !hazard && (!iss_valid || iss_ready);
    assign accept    = dec_valid && dec_ready;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        rs1_val = '0;
        rs2_val = '0;
        if (dec_rs1 != 5'd0)
            rs1_val = rs1_hit ? wb.data : rf[dec_rs1];
        if (dec_rs2 != 5'd0)
            rs2_val = rs2_hit ? wb.data : rf[dec_rs2];
    end

    // Clear first, then set, so an accept claiming r wins over a write-back retiring r.
    always_comb begin
        busy_clr = '0;
        busy_set = '0;
        if (wb_write)
            busy_clr[wb.adr] = 1'b1;
        if (accept && dec_rd_we)
            busy_set[dec_rd] = 1'b1;
        busy_nxt = (busy_all & ~busy_clr) | busy_set;
    end

    // NOTE: the register array is reset on purpose: reads after reset must return 0,
    // so it cannot be treated as an uninitialised RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < nreg; i++)
                rf[i] <= '0;
        end else if (wb_write) begin
            rf[wb.adr] <= wb.data;
        end
    end

    // NOTE: sequential state is updated with <= only; = would let other flops see the new value this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else if (flush)
            busy <= '0;
        else
            busy <= busy_nxt[nreg-1:1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid    <= 1'b0;
            iss_rs1_data <= '0;
            iss_rs2_data <= '0;
            iss_rd       <= '0;
            iss_rd_we    <= 1'b0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (accept) begin
            iss_valid    <= 1'b1;
            iss_rs1_data <= rs1_val;
            iss_rs2_data <= rs2_val;
            iss_rd       <= dec_rd;
            iss_rd_we    <= dec_rd_we;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_manager.sv
// Directed bench for reg_manager: reset/x0, RAW stall with bypass, WAW set/clear,
// backpressure, flush and asynchronous reset, each against hand-computed values.

module tb_reg_manager;
    import cpu_parameters::*;

    logic            clk = 1'b0;
    logic            rst;
    wb_bus           wb;
    logic            wb_valid;
    logic            flush;
    logic            dec_valid;
    logic            dec_ready;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic [4:0]      dec_rd;
    logic            dec_rs1_use;
    logic            dec_rs2_use;
    logic            dec_rd_we;
    logic            iss_valid;
    logic            iss_ready;
    logic [xlen-1:0] iss_rs1_data;
    logic [xlen-1:0] iss_rs2_data;
    logic [4:0]      iss_rd;
    logic            iss_rd_we;

    int n_cmp = 0;
    int n_bad = 0;

    reg_manager dut (
        .clk          (clk),
        .rst          (rst),
        .wb           (wb),
        .wb_valid     (wb_valid),
        .flush        (flush),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_rs1      (dec_rs1),
        .dec_rs2      (dec_rs2),
        .dec_rd       (dec_rd),
        .dec_rs1_use  (dec_rs1_use),
        .dec_rs2_use  (dec_rs2_use),
        .dec_rd_we    (dec_rd_we),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_rs1_data (iss_rs1_data),
        .iss_rs2_data (iss_rs2_data),
        .iss_rd       (iss_rd),
        .iss_rd_we    (iss_rd_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; afterwards inputs may be changed and outputs sampled safely.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic dec(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we);
        dec_valid   = 1'b1;
        dec_rs1     = rs1;
        dec_rs1_use = u1;
        dec_rs2     = rs2;
        dec_rs2_use = u2;
        dec_rd      = rd;
        dec_rd_we   = we;
    endtask

    task automatic idle();
        dec_valid   = 1'b0;
        dec_rs1_use = 1'b0;
        dec_rs2_use = 1'b0;
        dec_rd_we   = 1'b0;
    endtask

    task automatic wb_drive(input logic v, input logic [4:0] adr, input logic [31:0] data);
        wb_valid = v;
        wb.adr   = adr;
        wb.data  = data;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        flush     = 1'b0;
        iss_ready = 1'b1;
        dec_rs1   = '0;
        dec_rs2   = '0;
        dec_rd    = '0;
        idle();
        wb_drive(1'b0, 5'd0, 32'h0);
        step();
        step();
        rst = 1'b0;
        #1;
        check("rst_iss_valid", iss_valid, 0);
        check("rst_dec_ready", dec_ready, 1);
        check("rst_iss_rd", iss_rd, 0);

        // Reset and x0
        dec(5'd0, 1, 5'd5, 1, 5'd0, 0);
        step();
        check("x0_valid", iss_valid, 1);
        check("x0_rs1", iss_rs1_data, 0);
        check("x0_rs2_after_rst", iss_rs2_data, 0);
        idle();
        wb_drive(1'b1, 5'd0, 32'hDEAD);
        step();
        dec(5'd0, 1, 5'd5, 1, 5'd0, 0);
        wb_drive(1'b1, 5'd5, 32'hA5A5);
        step();
        wb_drive(1'b0, 5'd0, 32'h0);
        idle();
        check("x0_ignores_write", iss_rs1_data, 0);
        check("bypass_rs2", iss_rs2_data, 32'hA5A5);

        // RAW stall and bypass
        dec(5'd0, 1, 5'd0, 0, 5'd3, 1);
        #1;
        check("raw_addi_ready", dec_ready, 1);
        step();
        dec(5'd3, 1, 5'd0, 0, 5'd4, 1);
        #1;
        check("raw_stall_c1", dec_ready, 0);
        step();
        check("raw_drain", iss_valid, 0);
        check("raw_stall_c2", dec_ready, 0);
        step();
        wb_drive(1'b1, 5'd3, 32'h1234);
        #1;
        check("raw_ready_on_wb", dec_ready, 1);
        step();
        wb_drive(1'b0, 5'd0, 32'h0);
        idle();
        check("raw_rs1_bypass", iss_rs1_data, 32'h1234);
        check("raw_rd", iss_rd, 4);
        check("raw_rd_we", iss_rd_we, 1);
        wb_drive(1'b1, 5'd4, 32'h44);
        step();
        wb_drive(1'b0, 5'd0, 32'h0);

        // WAW with simultaneous set/clear on x7
        dec(5'd0, 0, 5'd0, 0, 5'd7, 1);
        step();
        dec(5'd0, 0, 5'd0, 0, 5'd7, 1);
        wb_drive(1'b1, 5'd7, 32'h77);
        #1;
        check("waw_ready", dec_ready, 1);
        step();
        wb_drive(1'b0, 5'd0, 32'h0);
        dec(5'd7, 1, 5'd0, 0, 5'd0, 0);
        #1;
        check("waw_busy_kept", dec_ready, 0);
        step();
        wb_drive(1'b1, 5'd7, 32'h99);
        #1;
        check("waw_release", dec_ready, 1);
        step();
        wb_drive(1'b0, 5'd0, 32'h0);
        check("waw_rs1", iss_rs1_data, 32'h99);

        // Backpressure
        dec(5'd3, 1, 5'd5, 1, 5'd10, 0);
        step();
        iss_ready = 1'b0;
        dec(5'd5, 1, 5'd0, 0, 5'd11, 1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_dec_ready", dec_ready, 0);
            check("bp_valid", iss_valid, 1);
            check("bp_rs1", iss_rs1_data, 32'h1234);
            check("bp_rs2", iss_rs2_data, 32'hA5A5);
            check("bp_rd", iss_rd, 10);
            step();
        end
        iss_ready = 1'b1;
        #1;
        check("bp_release_ready", dec_ready, 1);
        step();
        idle();
        check("bp_next_valid", iss_valid, 1);
        check("bp_next_rs1", iss_rs1_data, 32'hA5A5);
        check("bp_next_rd", iss_rd, 11);

        // Flush
        dec(5'd0, 0, 5'd0, 0, 5'd4, 1);
        step();
        dec(5'd0, 0, 5'd0, 0, 5'd9, 1);
        step();
        idle();
        iss_ready = 1'b0;
        flush = 1'b1;
        wb_drive(1'b1, 5'd9, 32'h55);
        #1;
        check("flush_valid_before", iss_valid, 1);
        check("flush_blocks_ready", dec_ready, 0);
        step();
        flush = 1'b0;
        iss_ready = 1'b1;
        wb_drive(1'b0, 5'd0, 32'h0);
        check("flush_valid_after", iss_valid, 0);
        dec(5'd9, 1, 5'd4, 1, 5'd0, 0);
        #1;
        check("flush_no_stall", dec_ready, 1);
        step();
        idle();
        check("flush_x9", iss_rs1_data, 32'h55);
        check("flush_x4", iss_rs2_data, 32'h44);

        // Asynchronous reset mid-operation
        dec(5'd0, 0, 5'd0, 0, 5'd2, 1);
        step();
        idle();
        iss_ready = 1'b0;
        check("ar_valid_before", iss_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_valid_drop", iss_valid, 0);
        check("ar_dec_ready", dec_ready, 1);
        rst = 1'b0;
        iss_ready = 1'b1;
        dec(5'd2, 1, 5'd0, 0, 5'd0, 0);
        #1;
        check("ar_x2_no_stall", dec_ready, 1);
        step();
        idle();
        check("ar_x2_value", iss_rs1_data, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
